mod_exp_ctrl: RTL and testbench



---
 rtl/mod_exp_pkg.sv | 35 +++
 rtl/mod_exp_ctrl_mul_req.sv | 74 +++++++
 rtl/mod_exp_ctrl.sv | 138 +++++++++++++
 tb/tb_mod_exp_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared constants, FSM/handshake encodings and priority encoder for mod_exp_ctrl
package mod_exp_pkg;

  localparam int K    = 192;
  localparam int LOGK = 8;

  localparam logic [K-1:0] M        = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
  localparam logic [K-1:0] R_MOD_M  = 192'h000000000000000000000000000000010000000000000001;
  localparam logic [K-1:0] R2_MOD_M = 192'h000000000000000100000000000000020000000000000001;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TO_MONT   = 3'd1,
    ST_SQR       = 3'd2,
    ST_MUL       = 3'd3,
    ST_NEXT      = 3'd4,
    ST_FROM_MONT = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_ISSUE   = 2'd1,
    PH_WAIT_LO = 2'd2,
    PH_WAIT_HI = 2'd3
  } phase_e;

  // Index of the highest set bit; 0 when v is zero (callers test for zero separately).
  function automatic logic [LOGK-1:0] msb_idx(input logic [K-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < K; i++)
      if (v[i]) msb_idx = LOGK'(i);
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_mul_req.sv
// mod_mul_req: one Montgomery product request -> start pulse, stale-done drain, result capture
module mod_mul_req
  import mod_exp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [K-1:0] op_a,
  input  logic [K-1:0] op_b,
  output logic         ack,
  output logic [K-1:0] res,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic         mm_start,
  input  logic [K-1:0] mm_z,
  input  logic         mm_done
);

  phase_e       phase_q, phase_d;
  logic [K-1:0] mm_x_q, mm_x_d, mm_y_q, mm_y_d, res_q, res_d;
  logic         mm_start_q, mm_start_d, ack_q, ack_d;

  // Handshake sequencing; operands latch on request and stay put until the next request.
  always_comb begin
    phase_d    = phase_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    res_d      = res_q;
    mm_start_d = 1'b0;
    ack_d      = 1'b0;
    case (phase_q)
      PH_IDLE: if (req) begin
        mm_x_d     = op_a;
        mm_y_d     = op_b;
        mm_start_d = 1'b1;
        phase_d    = PH_ISSUE;
      end
      PH_ISSUE:   phase_d = PH_WAIT_LO;
      PH_WAIT_LO: if (!mm_done) phase_d = PH_WAIT_HI;
      PH_WAIT_HI: if (mm_done) begin
        res_d   = mm_z;
        ack_d   = 1'b1;
        phase_d = PH_IDLE;
      end
      default:    phase_d = PH_IDLE;
    endcase
  end

  // Handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_IDLE;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      res_q      <= '0;
      mm_start_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      res_q      <= res_d;
      mm_start_q <= mm_start_d;
      ack_q      <= ack_d;
    end
  end

  assign mm_x     = mm_x_q;
  assign mm_y     = mm_y_q;
  assign mm_start = mm_start_q;
  assign res      = res_q;
  assign ack      = ack_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right Montgomery square-and-multiply sequencer (MOD_EXP_SKIP_LEADING_ZERO_EN skips leading-zero squarings)
module mod_exp_ctrl
  import mod_exp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] x,
  input  logic [K-1:0] e,
  output logic [K-1:0] z,
  output logic         done,
  output logic         busy,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic         mm_start,
  input  logic [K-1:0] mm_z,
  input  logic         mm_done
);

  state_e          state_q, state_d;
  logic [LOGK-1:0] idx_q, idx_d;
  logic [K-1:0]    a_q, a_d, xb_q, xb_d, x_q, x_d, e_q, e_d, z_q, z_d;
  logic            done_q, done_d, busy_q, busy_d, iss_q, iss_d;
  logic            req, ack, mp_state;
  logic [K-1:0]    op_a, op_b, res;

  // Operand selection for the product owned by the current state.
  always_comb begin
    mp_state = (state_q == ST_TO_MONT) || (state_q == ST_SQR) ||
               (state_q == ST_MUL) || (state_q == ST_FROM_MONT);
    req      = mp_state && !iss_q;
    op_a     = (state_q == ST_TO_MONT) ? x_q : a_q;
    op_b     = (state_q == ST_TO_MONT)   ? R2_MOD_M :
               (state_q == ST_MUL)       ? xb_q :
               (state_q == ST_FROM_MONT) ? K'(1) : a_q;
    iss_d    = ack ? 1'b0 : (req ? 1'b1 : iss_q);
  end

  // Exponentiation FSM: each product state advances only on the multiplier ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    xb_d    = xb_q;
    x_d     = x_q;
    e_d     = e_q;
    z_d     = z_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        x_d     = x;
        e_d     = e;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = ST_TO_MONT;
      end
      ST_TO_MONT: if (ack) begin
        xb_d    = res;
        a_d     = R_MOD_M;
`ifdef MOD_EXP_SKIP_LEADING_ZERO_EN
        idx_d   = msb_idx(e_q);
        state_d = (|e_q) ? ST_SQR : ST_FROM_MONT;
`else
        idx_d   = LOGK'(K - 1);
        state_d = ST_SQR;
`endif
      end
      ST_SQR: if (ack) begin
        a_d     = res;
        state_d = e_q[idx_q] ? ST_MUL : ST_NEXT;
      end
      ST_MUL: if (ack) begin
        a_d     = res;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
        state_d = (idx_q == '0) ? ST_FROM_MONT : ST_SQR;
      end
      ST_FROM_MONT: if (ack) begin
        a_d     = res;
        z_d     = res;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      xb_q    <= '0;
      x_q     <= '0;
      e_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      iss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      xb_q    <= xb_d;
      x_q     <= x_d;
      e_q     <= e_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      iss_q   <= iss_d;
    end
  end

  mod_mul_req u_req (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .ack      (ack),
    .res      (res),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_start (mm_start),
    .mm_z     (mm_z),
    .mm_done  (mm_done)
  );

  assign z    = z_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: random and directed modular exponentiation checks against a behavioural model
module tb_mod_exp_ctrl;

  localparam int K = 192;
  localparam logic [K-1:0] MM  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
  localparam logic [K-1:0] RR  = 192'h000000000000000000000000000000010000000000000001;
  localparam logic [K-1:0] RR2 = 192'h000000000000000100000000000000020000000000000001;

  logic         clk = 1'b0, rst_n, start;
  logic [K-1:0] x, e, z, mm_x, mm_y;
  logic         done, busy, mm_start;
  logic [K-1:0] mm_z = '0;
  logic         mm_done = 1'b1;

  int total = 0, bad = 0;
  int pcount = 0, p0 = 0, exp_p = 0;
  logic [K-1:0] exp_z = '0;

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .e(e), .z(z), .done(done), .busy(busy),
    .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start), .mm_z(mm_z), .mm_done(mm_done)
  );

  function automatic logic [K-1:0] mulmod(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [2*K-1:0] p;
    p = {{K{1'b0}}, a} * {{K{1'b0}}, b};
    p = p % {{K{1'b0}}, MM};
    return p[K-1:0];
  endfunction

  // a*b*2^-K mod M by K modular halvings.
  function automatic logic [K-1:0] mp(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K:0] t;
    t = {1'b0, mulmod(a, b)};
    for (int i = 0; i < K; i++) t = t[0] ? (t + {1'b0, MM}) >> 1 : t >> 1;
    return t[K-1:0];
  endfunction

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] ev);
    logic [K-1:0] r;
    r = 1;
    for (int i = K - 1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (ev[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic int exp_pulses(input logic [K-1:0] ev);
    int pc = $countones(ev);
`ifdef MOD_EXP_SKIP_LEADING_ZERO_EN
    int hi = -1;
    for (int i = 0; i < K; i++) if (ev[i]) hi = i;
    return (hi < 0) ? 2 : hi + 1 + pc + 2;
`else
    return K + pc + 2;
`endif
  endfunction

  function automatic logic [K-1:0] rand_k();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Multiplier model: done drops a cycle after the start edge, result after 1..3 more cycles.
  logic ms1 = 1'b0, ms2 = 1'b0, mrun = 1'b0;
  int   mcnt = 0;
  always @(posedge clk) begin
    ms1 <= mm_start;
    ms2 <= ms1;
    if (ms1 && !ms2) begin
      mm_done <= 1'b0;
      mrun    <= 1'b1;
      mcnt    <= $urandom_range(1, 3);
    end else if (mrun) begin
      if (mcnt == 0) begin
        mm_z    <= mp(mm_x, mm_y);
        mm_done <= 1'b1;
        mrun    <= 1'b0;
      end else mcnt <= mcnt - 1;
    end
  end

  // mm_start pulse count, width and spacing.
  int   low_run = 2;
  logic prev_hi = 1'b0, seen = 1'b0;
  always @(negedge clk) begin
    if (mm_start) begin
      pcount++;
      chk("mm_start_width", K'(prev_hi), K'(0));
      chk("mm_start_gap", K'(low_run >= 2 || !seen), K'(1));
      low_run = 0;
      prev_hi = 1'b1;
      seen    = 1'b1;
    end else begin
      low_run++;
      prev_hi = 1'b0;
    end
  end

  // Whenever done is high the result must be the model's and busy must be low.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      chk("z_while_done", z, exp_z);
      chk("busy_while_done", K'(busy), K'(0));
    end
  end

  task automatic launch(input logic [K-1:0] xi, input logic [K-1:0] ei);
    x = xi;
    e = ei;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_z = modexp(xi, ei);
    exp_p = exp_pulses(ei);
    p0    = pcount;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout actual=no_done required=done", nm);
  endtask

  task automatic finish_op(input string nm);
    wait_done(nm);
    chk({nm, "_z"}, z, exp_z);
    chk({nm, "_pulses"}, K'(pcount - p0), K'(exp_p));
    chk({nm, "_busy"}, K'(busy), K'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    e = '0;
    repeat (3) @(negedge clk);
    chk("rst_z", z, K'(0));
    chk("rst_done", K'(done), K'(0));
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_mm_start", K'(mm_start), K'(0));
    chk("rst_mm_x", mm_x, K'(0));
    chk("rst_mm_y", mm_y, K'(0));
    rst_n = 1'b1;
    chk("pin_modexp", modexp(2, 10), K'(1024));
    chk("pin_mp_to_mont", mp(1, RR2), RR);
    chk("pin_mp_one", mp(RR, RR), RR);
    chk("pin_fermat", modexp(2, MM - 1), K'(1));
    @(negedge clk);
    launch(2, 10);
    chk("accept_busy", K'(busy), K'(1));
    finish_op("x2_e10");
    chk("x2_e10_lit", z, K'(1024));
`ifdef MOD_EXP_SKIP_LEADING_ZERO_EN
    chk("x2_e10_pulses_lit", K'(pcount - p0), K'(8));
`else
    chk("x2_e10_pulses_lit", K'(pcount - p0), K'(196));
`endif
    @(negedge clk);
    launch(3, 0);
    finish_op("x3_e0");
    chk("x3_e0_lit", z, K'(1));
    @(negedge clk);
    launch(0, 5);
    finish_op("x0_e5");
    chk("x0_e5_lit", z, K'(0));
    @(negedge clk);
    launch(2, MM - 1);
    finish_op("fermat");
    chk("fermat_lit", z, K'(1));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      launch(rand_k() % MM, rand_k());
      finish_op("random");
    end
    @(negedge clk);
    launch(rand_k() % MM, rand_k());
    repeat (50) @(negedge clk);
    x = 7;
    e = 9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignored_start");
    @(negedge clk);
    launch(7, rand_k());
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", K'(busy), K'(0));
    chk("midrst_done", K'(done), K'(0));
    chk("midrst_mm_start", K'(mm_start), K'(0));
    rst_n = 1'b1;
    @(negedge clk);
    launch(5, 3);
    finish_op("after_reset");
    chk("after_reset_lit", z, K'(125));
    @(negedge clk);
    launch(rand_k() % MM, rand_k());
    finish_op("b2b_first");
    launch(rand_k() % MM, rand_k());
    finish_op("b2b_second");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
